ecc_mem_scrubber: RTL and testbench

ECC_MEM_SCRUBBER -- requirements
Module: ecc_mem_scrubber

---
 rtl/ecc_mem_scrubber_pkg.sv | 27 ++
 rtl/ecc_mem_scrubber_if.sv | 35 +++
 rtl/ecc_mem_scrubber_timer.sv | 38 +++
 rtl/ecc_mem_scrubber.sv | 174 +++++++++++++++++
 tb/tb_ecc_mem_scrubber.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_mem_scrubber_pkg.sv
// Shared types for the ECC memory scrubber: FSM state encoding and latency-counter sizing.
// The counter only ever holds latency-1, so its width tracks the larger of the two memory latencies.
package ecc_scrub_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    CHECK,
    WR_BACK,
    WR_WAIT,
    NEXT,
    DONE
  } scrub_state_e;

  localparam int unsigned DEF_READ_LATENCY  = 4;
  localparam int unsigned DEF_WRITE_LATENCY = 5;

  function automatic int unsigned lat_cnt_width(input int unsigned rd_lat, input int unsigned wr_lat);
    int unsigned max_lat;
    max_lat = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return (max_lat <= 2) ? 1 : $clog2(max_lat);
  endfunction

  localparam int unsigned LAT_CNT_W = lat_cnt_width(DEF_READ_LATENCY, DEF_WRITE_LATENCY);

endpackage

// File: rtl/ecc_mem_scrubber_if.sv
// Single-port ECC memory bus between the scrubber (master) and the memory (slave).
// i_dout/i_error are the memory's read response and are qualified by the scrubber's own latency count.
interface ecc_mem_scrubber_if
  import ecc_scrub_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);

  logic                  o_en;
  logic                  o_we;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [DATA_WIDTH-1:0] o_din;
  logic [DATA_WIDTH-1:0] i_dout;
  logic                  i_error;

  modport master (
    output o_en,
    output o_we,
    output o_addr,
    output o_din,
    input  i_dout,
    input  i_error
  );

  modport slave (
    input  o_en,
    input  o_we,
    input  o_addr,
    input  o_din,
    output i_dout,
    output i_error
  );

endinterface

// File: rtl/ecc_mem_scrubber_timer.sv
// Loadable down-counter with a zero flag; paces both the read-response and write-commit waits.
// Load wins over decrement; the count parks at zero rather than wrapping.
module scrub_wait_timer
  import ecc_scrub_pkg::*;
#(
  parameter int unsigned W = LAT_CNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/ecc_mem_scrubber.sv
// Sweeps every word, reads it, and writes back the corrected word when the memory flags an ECC error.
// Error logging (count + last address) exists only when ECC_SCRUB_ERR_LOG_EN is defined; otherwise tied to 0.
module ecc_mem_scrubber
  import ecc_scrub_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int MEM_DEPTH     = 2**ADDR_WIDTH,
  parameter int READ_LATENCY  = DEF_READ_LATENCY,
  parameter int WRITE_LATENCY = DEF_WRITE_LATENCY
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  ecc_mem_scrubber_if.master    mem,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH:0]   o_err_count,
  output logic [ADDR_WIDTH-1:0] o_last_err_addr
);

  localparam int unsigned CNT_W = lat_cnt_width(READ_LATENCY, WRITE_LATENCY);

  scrub_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  err_cap_q, err_cap_d;
  logic                  abort_q, abort_d;

  logic                  tmr_load;
  logic [CNT_W-1:0]      tmr_val;
  logic                  tmr_dec;
  logic                  tmr_zero;

  scrub_wait_timer #(
    .W (CNT_W)
  ) u_wait_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .i_dec      (tmr_dec),
    .o_zero     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    din_d     = din_q;
    err_cap_d = err_cap_q;
    abort_d   = abort_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RD_REQ;
          addr_d  = '0;
          abort_d = 1'b0;
        end
      end
      RD_REQ: begin
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(READ_LATENCY - 1);
        state_d  = i_abort ? DONE : RD_WAIT;
      end
      RD_WAIT: begin
        if (i_abort) begin
          state_d = DONE;
        end else if (tmr_zero) begin
          din_d     = mem.i_dout;
          err_cap_d = mem.i_error;
          state_d   = CHECK;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      CHECK: begin
        if (i_abort) begin
          state_d = DONE;
        end else begin
          state_d = err_cap_q ? WR_BACK : NEXT;
        end
      end
      WR_BACK: begin
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(WRITE_LATENCY - 1);
        abort_d  = abort_q | i_abort;
        state_d  = WR_WAIT;
      end
      WR_WAIT: begin
        // An abort here must not cut the write short; it is remembered until the commit time elapses.
        abort_d = abort_q | i_abort;
        if (tmr_zero) begin
          state_d = (abort_q || i_abort) ? DONE : NEXT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      NEXT: begin
        if (i_abort || (addr_q == ADDR_WIDTH'(MEM_DEPTH - 1))) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = RD_REQ;
        end
      end
      DONE: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      din_q     <= '0;
      err_cap_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      err_cap_q <= err_cap_d;
      abort_q   <= abort_d;
    end
  end

  assign mem.o_en   = (state_q == RD_REQ) || (state_q == WR_BACK);
  assign mem.o_we   = (state_q == WR_BACK);
  assign mem.o_addr = addr_q;
  assign mem.o_din  = din_q;
  assign o_busy     = (state_q != IDLE) && (state_q != DONE);
  assign o_done     = (state_q == DONE);

`ifdef ECC_SCRUB_ERR_LOG_EN
  localparam int CW = ADDR_WIDTH + 1;

  logic                  start_acc;
  logic                  log_err;
  logic [CW-1:0]         err_cnt_q;
  logic [ADDR_WIDTH-1:0] last_err_q;

  assign start_acc = (state_q == IDLE) && i_start;
  assign log_err   = (state_q == CHECK) && err_cap_q && !i_abort;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_cnt_q  <= '0;
      last_err_q <= '0;
    end else if (start_acc) begin
      err_cnt_q  <= '0;
    end else if (log_err) begin
      if (err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + CW'(1);
      end
      last_err_q <= addr_q;
    end
  end

  assign o_err_count     = err_cnt_q;
  assign o_last_err_addr = last_err_q;
`else
  assign o_err_count     = '0;
  assign o_last_err_addr = '0;
`endif

endmodule

// File: tb/tb_ecc_mem_scrubber.sv
// Scoreboarded bench: each sweep's expected memory accesses are queued at start and matched as they appear.
module tb_ecc_mem_scrubber;

  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int DEPTH = 8;
  localparam int RL   = 4;
  localparam int WL   = 5;

  // Cycle distances between consecutive memory accesses, from the state sequence.
  localparam int RD_RD_GAP = RL + 3;
  localparam int RD_WR_GAP = RL + 2;
  localparam int WR_RD_GAP = WL + 2;

`ifdef ECC_SCRUB_ERR_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    int            gap;
  } acc_t;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic          i_abort;
  logic          o_busy;
  logic          o_done;
  logic [AW:0]   o_err_count;
  logic [AW-1:0] o_last_err_addr;

  ecc_mem_scrubber_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_if ();

  ecc_mem_scrubber #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .MEM_DEPTH     (DEPTH),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_start         (i_start),
    .i_abort         (i_abort),
    .mem             (mem_if),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_err_count     (o_err_count),
    .o_last_err_addr (o_last_err_addr)
  );

  always #5 i_clk = ~i_clk;

  int   n_pass  = 0;
  int   n_total = 0;
  acc_t sb_q[$];
  logic [DW-1:0] mem_d [DEPTH];
  bit   flag [DEPTH];
  int   exp_cnt;
  int   exp_last;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Memory model: answers a read exactly RL edges after the request edge, and drives
  // the inverted word/flag on every other cycle so a mistimed capture is visible.
  int rd_cnt = 0;
  int rd_a   = 0;
  initial begin
    mem_if.i_dout  = '0;
    mem_if.i_error = 1'b0;
    forever begin
      @(negedge i_clk);
      if (mem_if.o_en && !mem_if.o_we) begin
        rd_cnt = RL;
        rd_a   = int'(mem_if.o_addr);
        mem_if.i_dout  = ~mem_d[rd_a];
        mem_if.i_error = ~flag[rd_a];
      end else if (rd_cnt > 0) begin
        rd_cnt--;
        mem_if.i_dout  = (rd_cnt == 0) ? mem_d[rd_a] : ~mem_d[rd_a];
        mem_if.i_error = (rd_cnt == 0) ? flag[rd_a] : ~flag[rd_a];
      end else begin
        mem_if.i_dout  = ~mem_d[rd_a];
        mem_if.i_error = ~flag[rd_a];
      end
    end
  end

  // Access monitor: every enabled memory cycle must match the head of the scoreboard.
  int cyc = 0;
  int last_cyc = 0;
  initial begin
    acc_t e;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (mem_if.o_en) begin
        if (sb_q.size() == 0) begin
          chk("spurious_access", mem_if.o_en, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("acc_we", mem_if.o_we, e.we);
          chk("acc_addr", mem_if.o_addr, e.addr);
          if (e.we) chk("acc_din", mem_if.o_din, e.din);
          if (e.gap != 0) chk("acc_gap", cyc - last_cyc, e.gap);
        end
        last_cyc = cyc;
      end else if (mem_if.o_we) begin
        chk("we_without_en", mem_if.o_we, 1'b0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic set_mem(input logic [DW-1:0] base, input logic [DW-1:0] step, input logic [DEPTH-1:0] mask);
    for (int a = 0; a < DEPTH; a++) begin
      mem_d[a] = base + DW'(a) * step;
      flag[a]  = mask[a];
    end
  endtask

  task automatic push_sweep(input int last_a);
    acc_t e;
    int   gap;
    gap      = 0;
    exp_cnt  = 0;
    exp_last = 0;
    for (int a = 0; a <= last_a; a++) begin
      e.we = 1'b0; e.addr = AW'(a); e.din = '0; e.gap = gap;
      sb_q.push_back(e);
      gap = RD_RD_GAP;
      if (flag[a]) begin
        e.we = 1'b1; e.din = mem_d[a]; e.gap = RD_WR_GAP;
        sb_q.push_back(e);
        gap = WR_RD_GAP;
        exp_cnt++;
        exp_last = a;
      end
    end
  endtask

  task automatic start_sweep(input bit with_abort);
    i_start = 1'b1;
    i_abort = with_abort;
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("busy_after_start", o_busy, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!o_done && n < 400) begin
      tick();
      n++;
    end
    chk(tag, o_done, 1'b1);
    tick();
    chk("done_one_cycle", o_done, 1'b0);
    chk("idle_not_busy", o_busy, 1'b0);
  endtask

  task automatic wait_acc(input string tag, input bit we, input int addr);
    int n;
    n = 0;
    while (!(mem_if.o_en && mem_if.o_we == we && int'(mem_if.o_addr) == addr) && n < 400) begin
      tick();
      n++;
    end
    chk(tag, {mem_if.o_en, mem_if.o_we, mem_if.o_addr}, {1'b1, we, AW'(addr)});
  endtask

  task automatic check_log(input int cnt, input int last, input bit check_last);
    chk("err_count", o_err_count, LOG_EN ? cnt : 0);
    if (check_last) chk("last_err_addr", o_last_err_addr, LOG_EN ? last : 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_en"},    mem_if.o_en, 1'b0);
    chk({tag, "_we"},    mem_if.o_we, 1'b0);
    chk({tag, "_busy"},  o_busy, 1'b0);
    chk({tag, "_done"},  o_done, 1'b0);
    chk({tag, "_addr"},  mem_if.o_addr, 0);
    chk({tag, "_din"},   mem_if.o_din, 0);
    chk({tag, "_errcnt"}, o_err_count, 0);
    chk({tag, "_lasterr"}, o_last_err_addr, 0);
  endtask

  initial begin
    int n;
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    set_mem(8'h10, 8'h01, 8'h00);
    tick(3);
    check_all_zero("reset");
    i_rst = 1'b0;
    tick(2);

    // Clean sweep; start and abort together in IDLE, start wins.
    set_mem(8'h10, 8'h01, 8'h00);
    push_sweep(DEPTH - 1);
    start_sweep(1'b1);
    wait_done("clean_done");
    check_log(exp_cnt, exp_last, 1'b0);
    chk("clean_sb_drained", sb_q.size(), 0);

    // Single error at address 2 returning 0xA2.
    set_mem(8'hA0, 8'h01, 8'b0000_0100);
    push_sweep(DEPTH - 1);
    start_sweep(1'b0);
    wait_done("err2_done");
    tick(3);
    check_log(exp_cnt, exp_last, 1'b1);
    chk("err2_sb_drained", sb_q.size(), 0);

    // Errors at 0, 5 and 7.
    set_mem(8'h31, 8'h05, 8'b1010_0001);
    push_sweep(DEPTH - 1);
    start_sweep(1'b0);
    wait_done("err057_done");
    check_log(exp_cnt, exp_last, 1'b1);
    chk("err057_sb_drained", sb_q.size(), 0);

    // Abort while waiting for the read of address 4.
    set_mem(8'h50, 8'h03, 8'h00);
    push_sweep(4);
    start_sweep(1'b0);
    wait_acc("abort_rd_reach4", 1'b0, 4);
    tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_rd_done", o_done, 1'b1);
    chk("abort_rd_busy", o_busy, 1'b0);
    tick(20);
    check_log(0, 0, 1'b0);
    chk("abort_rd_sb_drained", sb_q.size(), 0);

    // Abort during the write-commit wait: the write completes, then DONE.
    set_mem(8'h60, 8'h07, 8'b0000_0010);
    push_sweep(1);
    start_sweep(1'b0);
    wait_acc("abort_wr_reach_wr", 1'b1, 1);
    tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    n = 2;
    while (!o_done && n < 50) begin
      tick();
      n++;
    end
    chk("abort_wr_done_lat", n, WL + 1);
    tick(20);
    check_log(1, 1, 1'b1);
    chk("abort_wr_sb_drained", sb_q.size(), 0);

    // A second start mid-sweep must not restart the address sequence.
    set_mem(8'h70, 8'h02, 8'b0000_1000);
    push_sweep(DEPTH - 1);
    start_sweep(1'b0);
    tick(10);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done("restart_ignored_done");
    check_log(exp_cnt, exp_last, 1'b1);
    chk("restart_sb_drained", sb_q.size(), 0);

    // Reset during the write-commit wait.
    set_mem(8'h90, 8'h01, 8'b0000_0001);
    push_sweep(0);
    start_sweep(1'b0);
    wait_acc("rst_reach_wr", 1'b1, 0);
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_all_zero("rst_wrwait");
    tick(20);
    chk("rst_no_access", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
